// File: rtl/multicycle_adder.sv
// Multi-cycle WIDTH-bit add/subtract unit: CHUNK bits per clock with the carry
// rippling between cycles, valid/ready on both sides, carry and signed-overflow out.
module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("multicycle_adder: CHUNK must lie in 1..WIDTH and divide WIDTH");
        end
    endgenerate

    // Handshake: an input transfer happens on an edge where in_valid && in_ready,
    // an output transfer on an edge where out_valid && out_ready. Both ready/valid
    // outputs decode straight from the state register.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             last_chunk;
    logic             accept;
    logic             step;

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                a_chunk = a_q[k*CHUNK +: CHUNK];
                b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        last_chunk = (cnt_q == CW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last_chunk) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Subtraction is a + ~b + ~borrow, so the same chain serves both and the
    // final carry reads directly as "no borrow".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? ~cin : cin;
            cnt_q   <= '0;
        end else if (step) begin
            for (int k = 0; k < N; k++) begin
                if (cnt_q == CW'(k)) begin
                    s[k*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                end
            end
            carry_q <= chunk_sum[CHUNK];
            cnt_q   <= cnt_q + CW'(1);
            if (last_chunk) begin
                // The top chunk is being summed now, so its MSB is the result MSB.
                cout <= chunk_sum[CHUNK];
                ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: four configurations, each with a driver, an expected
// queue fed at acceptance and a monitor that pops on every output transfer.
module tb_multicycle_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Reference: plain integer arithmetic, returns {ovf, cout, s zero-extended to 16}.
    function automatic logic [17:0] model(input int w, input longint ua, input longint ub,
                                          input logic ci, input logic sb);
        longint m, c, full, sa, sbv, res;
        logic   co, ov;
        m = longint'(1) << w;
        c = ci ? 64'sd1 : 64'sd0;
        if (!sb) begin
            full = ua + ub + c;
            co   = (full >= m);
        end else begin
            full = ua - ub - c;
            co   = (ua >= ub + c);
        end
        sa  = (ua >= m / 2) ? ua - m : ua;
        sbv = (ub >= m / 2) ? ub - m : ub;
        res = sb ? (sa - sbv - c) : (sa + sbv + c);
        ov  = (res < -(m / 2)) || (res >= m / 2);
        return {ov, co, 16'(full & (m - 1))};
    endfunction

    generate
        for (genvar g = 0; g < 4; g++) begin : h
            localparam int W = (g == 0) ? 16 : (g == 1) ? 1 : (g == 2) ? 16 : 8;
            localparam int C = (g == 0) ? 4  : (g == 1) ? 1 : (g == 2) ? 16 : 1;
            localparam int N = W / C;

            logic         rst_n;
            logic         in_valid;
            logic         in_ready;
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         cin;
            logic         sub;
            logic         out_valid;
            logic         out_ready;
            logic [W-1:0] s;
            logic         cout;
            logic         ovf;

            int  rdy_mode = 0;
            bit  done = 1'b0;
            logic [17:0] exp_q[$];
            int          acc_q[$];

            multicycle_adder #(.WIDTH(W), .CHUNK(C)) dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_valid (in_valid),
                .in_ready (in_ready),
                .a        (a),
                .b        (b),
                .cin      (cin),
                .sub      (sub),
                .out_valid(out_valid),
                .out_ready(out_ready),
                .s        (s),
                .cout     (cout),
                .ovf      (ovf)
            );

            // Consumer: 0 = always ready, 1 = stalled, otherwise random backpressure.
            initial begin
                out_ready = 1'b1;
                forever begin
                    @(negedge clk);
                    case (rdy_mode)
                        0:       out_ready = 1'b1;
                        1:       out_ready = 1'b0;
                        default: out_ready = ($urandom_range(0, 3) != 0);
                    endcase
                end
            end

            // Monitor: latency on each rising out_valid, result on each output transfer.
            initial begin
                logic prev_ov;
                prev_ov = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        prev_ov = 1'b0;
                    end else begin
                        if (out_valid && !prev_ov) begin
                            if (acc_q.size() == 0) fail($sformatf("cfg%0d unexpected out_valid", g));
                            else check($sformatf("cfg%0d latency", g), 32'(cyc - acc_q.pop_front()), 32'(N));
                        end
                        if (out_valid && out_ready) begin
                            if (exp_q.size() == 0) fail($sformatf("cfg%0d extra result", g));
                            else check($sformatf("cfg%0d result {ovf,cout,s}", g),
                                       32'({ovf, cout, 16'(s)}), 32'(exp_q.pop_front()));
                        end
                        prev_ov = out_valid;
                    end
                end
            end

            task automatic check_reset_outputs(input string tag);
                check($sformatf("cfg%0d %s in_ready", g, tag), 32'(in_ready), 32'd1);
                check($sformatf("cfg%0d %s out_valid", g, tag), 32'(out_valid), 32'd0);
                check($sformatf("cfg%0d %s s", g, tag), 32'(s), 32'd0);
                check($sformatf("cfg%0d %s cout", g, tag), 32'(cout), 32'd0);
                check($sformatf("cfg%0d %s ovf", g, tag), 32'(ovf), 32'd0);
            endtask

            task automatic reset_dut(input int n);
                rst_n    = 1'b0;
                in_valid = 1'b0;
                a        = '0;
                b        = '0;
                cin      = 1'b0;
                sub      = 1'b0;
                @(negedge clk);
                check_reset_outputs("reset");
                repeat (n) @(negedge clk);
                rst_n = 1'b1;
            endtask

            task automatic send(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                input logic op_c, input logic op_s);
                int guard;
                guard = 0;
                @(negedge clk);
                while (!in_ready && guard < 500) begin
                    @(negedge clk);
                    guard++;
                end
                check($sformatf("cfg%0d accept ready", g), 32'(in_ready), 32'd1);
                if (in_ready) begin
                    a        = op_a;
                    b        = op_b;
                    cin      = op_c;
                    sub      = op_s;
                    in_valid = 1'b1;
                    exp_q.push_back(model(W, longint'(op_a), longint'(op_b), op_c, op_s));
                    acc_q.push_back(cyc + 1);
                    @(negedge clk);
                    in_valid = 1'b0;
                    a        = W'($urandom);
                    b        = W'($urandom);
                    cin      = 1'($urandom);
                    sub      = 1'($urandom);
                end
            endtask

            task automatic wait_drain();
                int guard;
                guard = 0;
                while (exp_q.size() != 0 && guard < 5000) begin
                    @(negedge clk);
                    guard++;
                end
                check($sformatf("cfg%0d drained", g), 32'(exp_q.size()), 32'd0);
            endtask

            if (g == 0) begin : directed
                initial begin
                    logic [17:0] e;
                    int          guard;
                    reset_dut(3);

                    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
                    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
                    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
                    send(16'h8000, 16'h0001, 1'b0, 1'b1);
                    send(16'h0005, 16'h0007, 1'b0, 1'b1);
                    send(16'h0005, 16'h0007, 1'b1, 1'b1);
                    wait_drain();

                    // Backpressure while new operands are offered.
                    rdy_mode = 1;
                    send(16'h1357, 16'h2468, 1'b0, 1'b0);
                    e = model(16, 64'h1357, 64'h2468, 1'b0, 1'b0);
                    guard = 0;
                    while (!out_valid && guard < 50) begin
                        @(negedge clk);
                        guard++;
                    end
                    a        = 16'hAAAA;
                    b        = 16'h5555;
                    cin      = 1'b1;
                    in_valid = 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        check("cfg0 stall out_valid", 32'(out_valid), 32'd1);
                        check("cfg0 stall in_ready", 32'(in_ready), 32'd0);
                        check("cfg0 stall s", 32'(s), 32'(e[15:0]));
                        check("cfg0 stall cout", 32'(cout), 32'(e[16]));
                    end
                    in_valid = 1'b0;
                    rdy_mode = 0;
                    wait_drain();
                    @(negedge clk);
                    check("cfg0 idle after release", 32'(in_ready), 32'd1);

                    // Reset during chunk 2 aborts; a fresh op then runs normally.
                    send(16'h1234, 16'h1111, 1'b0, 1'b0);
                    repeat (2) @(negedge clk);
                    rst_n = 1'b0;
                    #1;
                    check_reset_outputs("abort");
                    exp_q.delete();
                    acc_q.delete();
                    repeat (2) @(negedge clk);
                    check_reset_outputs("abort held");
                    rst_n = 1'b1;
                    send(16'h1234, 16'h1111, 1'b0, 1'b0);
                    wait_drain();

                    rdy_mode = 2;
                    for (int i = 0; i < 60; i++) begin
                        send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                    end
                    wait_drain();
                    check("cfg0 no pending latency", 32'(acc_q.size()), 32'd0);
                    done = 1'b1;
                end
            end else begin : sweep
                localparam int NDIR  = (W == 1) ? 8 : 0;
                localparam int NRAND = (W == 1) ? 24 : 200;
                initial begin
                    reset_dut(3);
                    for (int i = 0; i < NDIR; i++) begin
                        send(W'(i >> 2), W'(i >> 1), i[0], 1'b0);
                    end
                    rdy_mode = 2;
                    for (int i = 0; i < NRAND; i++) begin
                        send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                    end
                    wait_drain();
                    check($sformatf("cfg%0d no pending latency", g), 32'(acc_q.size()), 32'd0);
                    done = 1'b1;
                end
            end
        end
    endgenerate

    initial begin
        int guard;
        guard = 0;
        while (!(h[0].done && h[1].done && h[2].done && h[3].done) && guard < 60000) begin
            @(posedge clk);
            guard++;
        end
        if (!(h[0].done && h[1].done && h[2].done && h[3].done)) fail("watchdog: drivers did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
